// File: rtl/pulse_stretch.sv
// Stretches single-cycle trigger events into ON_CYCLES-long led pulses separated by OFF_CYCLES gaps.
// Events that arrive while busy are queued in a saturating counter and replayed in order.
module pulse_stretch #(
  parameter int ON_CYCLES  = 20,
  parameter int OFF_CYCLES = 20,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              clr_ovf,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = $clog2(MAX_CYC) + 1;
  localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              trig_q;
  logic              ovf_nxt;
  logic              led_nxt, busy_nxt;
  logic              evt, dequeue, start_fresh, count_evt, ovf_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      trig_q   <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
      led      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      trig_q   <= trig;
      pending  <= pend_nxt;
      overflow <= ovf_nxt;
      led      <= led_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    evt         = trig & ~trig_q;
    state_nxt   = state;
    timer_nxt   = timer;
    dequeue     = 1'b0;
    start_fresh = 1'b0;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          state_nxt = ON;
          timer_nxt = ON_LOAD;
          dequeue   = 1'b1;
        end else if (evt) begin
          state_nxt   = ON;
          timer_nxt   = ON_LOAD;
          start_fresh = 1'b1;
        end
      end
      ON: begin
        if (timer == '0) begin
          state_nxt = GAP;
          timer_nxt = OFF_LOAD;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      GAP: begin
        if (timer == '0) begin
          if (pending != '0) begin
            state_nxt = ON;
            timer_nxt = ON_LOAD;
            dequeue   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase

    // An event that coincides with a dequeue replaces the dequeued slot, so it can never overflow.
    count_evt = evt & ~start_fresh;
    ovf_set   = 1'b0;
    pend_nxt  = pending;
    if (count_evt && !dequeue) begin
      if (pending == PEND_MAX) ovf_set = 1'b1;
      else                     pend_nxt = pending + PEND_W'(1);
    end else if (dequeue && !count_evt) begin
      pend_nxt = pending - PEND_W'(1);
    end

    if (ovf_set)      ovf_nxt = 1'b1;
    else if (clr_ovf) ovf_nxt = 1'b0;
    else              ovf_nxt = overflow;
  end

  always_comb begin
    led_nxt  = (state_nxt == ON);
    busy_nxt = (state_nxt != IDLE);
  end

endmodule
